ct_mmu_sysmap_cfg: RTL

CT_MMU_SYSMAP_CFG -- requirements
Module: ct_mmu_sysmap_cfg

---
 rtl/ct_mmu_sysmap_cfg_pkg.sv | 13 +
 rtl/ct_mmu_sysmap_cmp.sv | 14 +
 rtl/ct_mmu_sysmap_cfg.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ct_mmu_sysmap_cfg_pkg.sv
// Shared constants and types for the system-map attribute lookup block.
// Holds the default flag, the write-select encodings and the flag field type.
package ct_mmu_sysmap_cfg_pkg;

  localparam int SYSMAP_FLG_WIDTH = 5;

  typedef logic [SYSMAP_FLG_WIDTH-1:0] sysmap_flg_t;

  localparam sysmap_flg_t SYSMAP_DEF_FLG  = 5'b01111;
  localparam logic        SYSMAP_SEL_BASE = 1'b0;
  localparam logic        SYSMAP_SEL_FLG  = 1'b1;

endpackage

// File: rtl/ct_mmu_sysmap_cmp.sv
// Single-region range compare: region covers [lo, hi), with lo forced to 0 for region 0.
module ct_mmu_sysmap_cmp #(
  parameter int AW = 28
) (
  input  logic [AW-1:0] pa,
  input  logic [AW-1:0] lo,
  input  logic [AW-1:0] hi,
  input  logic          is_first,
  output logic          hit
);

  assign hit = (is_first || (pa >= lo)) && (pa < hi);

endmodule

// File: rtl/ct_mmu_sysmap_cfg.sv
// System-map attribute lookup: shadow/active region tables programmed by CP0,
// a one-stage registered lookup, sticky lock and registered readback.
module ct_mmu_sysmap_cfg
  import ct_mmu_sysmap_cfg_pkg::*;
#(
  parameter int                   REGION_NUM = 8,
  parameter int                   PA_WIDTH   = 40,
  parameter int                   FLG_WIDTH  = 5,
  parameter logic [FLG_WIDTH-1:0] DEF_FLG    = SYSMAP_DEF_FLG
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst_b,
  input  logic                          mmu_sysmap_req_vld,
  input  logic [PA_WIDTH-13:0]          mmu_sysmap_pa,
  output logic                          sysmap_mmu_rsp_vld,
  output logic [FLG_WIDTH-1:0]          sysmap_mmu_flg,
  output logic [REGION_NUM-1:0]         sysmap_mmu_hit,
  input  logic                          cp0_sysmap_wen,
  input  logic [$clog2(REGION_NUM)-1:0] cp0_sysmap_widx,
  input  logic                          cp0_sysmap_wsel,
  input  logic [PA_WIDTH-13:0]          cp0_sysmap_wdata,
  input  logic                          cp0_sysmap_commit,
  input  logic                          cp0_sysmap_lock,
  output logic                          sysmap_cp0_werr,
  output logic                          sysmap_cp0_locked,
  input  logic [$clog2(REGION_NUM)-1:0] cp0_sysmap_ridx,
  output logic [PA_WIDTH-13:0]          sysmap_cp0_rbase,
  output logic [FLG_WIDTH-1:0]          sysmap_cp0_rflg
);

  localparam int              AW   = PA_WIDTH - 12;
  localparam int              IDXW = $clog2(REGION_NUM);
  localparam logic [IDXW:0]   RNUM = (IDXW+1)'(REGION_NUM);

  logic [AW-1:0]        sh_base_q  [REGION_NUM];
  logic [AW-1:0]        sh_base_d  [REGION_NUM];
  logic [FLG_WIDTH-1:0] sh_flg_q   [REGION_NUM];
  logic [FLG_WIDTH-1:0] sh_flg_d   [REGION_NUM];
  logic [AW-1:0]        act_base_q [REGION_NUM];
  logic [AW-1:0]        act_base_d [REGION_NUM];
  logic [FLG_WIDTH-1:0] act_flg_q  [REGION_NUM];
  logic [FLG_WIDTH-1:0] act_flg_d  [REGION_NUM];
  logic [AW-1:0]        lo_bound   [REGION_NUM];

  logic                  locked_q, locked_d;
  logic                  werr_q, werr_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [REGION_NUM-1:0] hit_q, hit_d, hit_raw;
  logic [FLG_WIDTH-1:0]  flg_q, flg_d, sel_flg;
  logic [AW-1:0]         rbase_q, rbase_d;
  logic [FLG_WIDTH-1:0]  rflg_q, rflg_d;
  logic                  widx_ok, ridx_ok, one_hot;

  always_comb begin
    lo_bound[0] = '0;
    for (int i = 1; i < REGION_NUM; i++) lo_bound[i] = act_base_q[i-1];
  end

  for (genvar i = 0; i < REGION_NUM; i++) begin : g_cmp
    ct_mmu_sysmap_cmp #(.AW(AW)) u_cmp (
      .pa       (mmu_sysmap_pa),
      .lo       (lo_bound[i]),
      .hi       (act_base_q[i]),
      .is_first (i == 0),
      .hit      (hit_raw[i])
    );
  end

  // Config path: commit reads the registered shadow, so a same-cycle write
  // lands only in the shadow; the lock gate uses the pre-edge lock state.
  always_comb begin
    sh_base_d  = sh_base_q;
    sh_flg_d   = sh_flg_q;
    act_base_d = act_base_q;
    act_flg_d  = act_flg_q;
    widx_ok    = {1'b0, cp0_sysmap_widx} < RNUM;
    locked_d   = locked_q | cp0_sysmap_lock;
    werr_d     = (cp0_sysmap_wen && (locked_q || !widx_ok)) ||
                 (cp0_sysmap_commit && locked_q);
    if (cp0_sysmap_commit && !locked_q) begin
      act_base_d = sh_base_q;
      act_flg_d  = sh_flg_q;
    end
    if (cp0_sysmap_wen && !locked_q && widx_ok) begin
      if (cp0_sysmap_wsel == SYSMAP_SEL_FLG)
        sh_flg_d[cp0_sysmap_widx] = cp0_sysmap_wdata[FLG_WIDTH-1:0];
      else
        sh_base_d[cp0_sysmap_widx] = cp0_sysmap_wdata;
    end
  end

  // Lookup: req_vld is a pure valid (no ready); every sampled request yields
  // rsp_vld for exactly one cycle, and hit/flg hold when no request is sampled.
  always_comb begin
    one_hot = (hit_raw != '0) && ((hit_raw & (hit_raw - REGION_NUM'(1))) == '0);
    sel_flg = '0;
    for (int i = 0; i < REGION_NUM; i++) begin
      if (hit_raw[i]) sel_flg = sel_flg | act_flg_q[i];
    end
    rsp_vld_d = mmu_sysmap_req_vld;
    hit_d     = mmu_sysmap_req_vld ? hit_raw : hit_q;
    flg_d     = mmu_sysmap_req_vld ? (one_hot ? sel_flg : DEF_FLG) : flg_q;
    ridx_ok   = {1'b0, cp0_sysmap_ridx} < RNUM;
    rbase_d   = ridx_ok ? act_base_q[cp0_sysmap_ridx] : '0;
    rflg_d    = ridx_ok ? act_flg_q[cp0_sysmap_ridx]  : '0;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < REGION_NUM; i++) begin
        sh_base_q[i]  <= '0;
        sh_flg_q[i]   <= DEF_FLG;
        act_base_q[i] <= '0;
        act_flg_q[i]  <= DEF_FLG;
      end
      locked_q  <= 1'b0;
      werr_q    <= 1'b0;
      rsp_vld_q <= 1'b0;
      hit_q     <= '0;
      flg_q     <= DEF_FLG;
      rbase_q   <= '0;
      rflg_q    <= '0;
    end else begin
      sh_base_q  <= sh_base_d;
      sh_flg_q   <= sh_flg_d;
      act_base_q <= act_base_d;
      act_flg_q  <= act_flg_d;
      locked_q   <= locked_d;
      werr_q     <= werr_d;
      rsp_vld_q  <= rsp_vld_d;
      hit_q      <= hit_d;
      flg_q      <= flg_d;
      rbase_q    <= rbase_d;
      rflg_q     <= rflg_d;
    end
  end

  assign sysmap_mmu_rsp_vld = rsp_vld_q;
  assign sysmap_mmu_hit     = hit_q;
  assign sysmap_mmu_flg     = flg_q;
  assign sysmap_cp0_werr    = werr_q;
  assign sysmap_cp0_locked  = locked_q;
  assign sysmap_cp0_rbase   = rbase_q;
  assign sysmap_cp0_rflg    = rflg_q;

endmodule
